alu_pwr_seq: RTL
================

Name: alu_pwr_seq

Overview:
Power-gating sequencer for the ALU power domain. It drives the ALU's alu_pwr_en and iso_en, and gates the ALU start strobe.
- Wakes the domain on demand: power first, then isolation release.
- Shuts the domain down after a programmable idle period: isolation first, then power off.
- Sits beside the ALU in top and replaces the static power/isolation pins with a sequenced pair.

Parameters:
PWRUP_CYC, 4, cycles alu_pwr_en is held high with iso_en still asserted before isolation release (>=1)
ISO_SETUP_CYC, 2, cycles iso_en is held asserted with power still on before alu_pwr_en drops (>=1)
IDLE_CYC, 16, consecutive idle cycles in ON before shutdown starts (>=1)
CNT_W, 8, width of internal counters and the optional wake counter

Ports:
clk  input  1  single clock; all logic on posedge
rst  input  1  synchronous, active-high reset
req  input  1  requester needs the ALU; level, held until ready seen
force_on  input  1  keep the domain powered; blocks shutdown
start_in  input  1  ALU start request from requester
busy  input  1  ALU busy from the ALU
alu_pwr_en  output  1  ALU domain power enable (registered)
iso_en  output  1  ALU output isolation (registered)
ready  output  1  domain powered and de-isolated (registered)
start_out  output  1  start to the ALU = start_in & ready (combinational)
start_drop  output  1  one-cycle pulse, registered: start_in seen while ready=0
state  output  3  current state encoding

Behaviour:
- Reset (rst=1 at posedge): state=OFF, alu_pwr_en=0, iso_en=1, ready=0, start_drop=0, all counters 0. Reset mid-sequence returns to OFF immediately; alu_pwr_en drops and iso_en rises in the same cycle.
- State encodings: OFF=0, PWR_UP=1, UNISO=2, ON=3, ISO=4, PWR_DN=5. Outputs are Moore, decoded from the state register.
- OFF (pwr=0, iso=1, ready=0): req|force_on -> PWR_UP.
- PWR_UP (pwr=1, iso=1): stays exactly PWRUP_CYC cycles, then -> UNISO. req/force_on dropping does not abort.
- UNISO (pwr=1, iso=0, ready=0): exactly 1 cycle (ALU output settling), then -> ON.
- ON (pwr=1, iso=0, ready=1):
  - A cycle is active if req|force_on|start_in|busy; otherwise it is idle.
  - The idle counter clears on active cycles and increments on idle cycles.
  - On the IDLE_CYC-th consecutive idle cycle -> ISO. With no activity, ON lasts exactly IDLE_CYC cycles.
- ISO (pwr=1, iso=1, ready=0): stays ISO_SETUP_CYC cycles, then -> PWR_DN. req|force_on during ISO aborts back to UNISO; power is never dropped.
- PWR_DN (pwr=0, iso=1): exactly 1 cycle, then -> OFF. req is not acted on here; OFF sees it next cycle.
- Wake latency: req rising in OFF at cycle 0 gives ready=1 at cycle PWRUP_CYC+2.
- Invariants, checked every cycle:
  - alu_pwr_en=0 implies iso_en=1.
  - iso_en falls only in the state after alu_pwr_en has been 1 for PWRUP_CYC cycles.
  - alu_pwr_en falls only after iso_en has been 1 for ISO_SETUP_CYC cycles.
  - ready=1 only in ON.
- start_in while ready=0 is not forwarded and gives start_drop=1 on the next cycle. It does not by itself wake the domain; req does.
- Counters are CNT_W wide; parameter values must fit. No wrap is possible because every count has a terminal compare.

Optional Feature:
Macro ALU_PWR_STATS_EN.
- Defined: adds output wake_cnt [CNT_W-1:0], cleared by rst. It increments on every OFF->PWR_UP transition and saturates at all-ones. ISO->UNISO aborts do not count.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then req=1 at cycle 0 (defaults) -> alu_pwr_en=1 at cycle 1, iso_en=0 at cycle 5, ready=1 at cycle 6; state sequence 0,1,1,1,1,2,3.
- In ON, drop all inputs -> ready stays 1 for 16 cycles, then ISO for 2 cycles (iso=1, pwr=1), PWR_DN 1 cycle (pwr=0), then OFF.
- busy held high 40 cycles in ON with req=0 -> no shutdown; after busy falls, shutdown begins 16 cycles later.
- req asserted in the 1st ISO cycle -> state goes ISO->UNISO->ON; alu_pwr_en never falls; wake_cnt unchanged (with ALU_PWR_STATS_EN).
- start_in=1 in OFF -> start_out=0 and start_drop=1 the next cycle; start_in=1 in ON -> start_out=1 the same cycle.
- rst asserted in PWR_UP cycle 2 -> next cycle state=OFF, pwr=0, iso=1, ready=0; with ALU_PWR_STATS_EN, 300 wake cycles with CNT_W=8 -> wake_cnt saturates at 255.

Source files
------------

// File: rtl/alu_pwr_seq.sv
// -----------------------------------------------------------------------------
// alu_pwr_seq -- power-gating sequencer for the ALU power domain.
//
// Wakes the ALU domain on demand (power on, wait, then release isolation) and
// shuts it down after a programmable idle period (isolate, wait, then power
// off). The ALU start strobe is only forwarded while the domain is ready.
//
// Optional feature macro: ALU_PWR_STATS_EN
//   defined   -> adds output wake_cnt, a saturating count of OFF->PWR_UP wakes
//   undefined -> wake_cnt port and logic are absent
//
// Parameters:
//   PWRUP_CYC      cycles powered but still isolated before isolation release
//   ISO_SETUP_CYC  cycles isolated but still powered before power drops
//   IDLE_CYC       consecutive idle cycles in ON before shutdown starts
//   CNT_W          width of the internal counter and of wake_cnt
//
// Ports:
//   clk         clock, all logic on posedge
//   rst         synchronous active-high reset
//   req         requester needs the ALU (level)
//   force_on    keep the domain powered, blocks shutdown
//   start_in    ALU start request from the requester
//   busy        ALU busy from the ALU
//   alu_pwr_en  ALU domain power enable (registered)
//   iso_en      ALU output isolation (registered)
//   ready       domain powered and de-isolated (registered)
//   start_out   start_in & ready (combinational)
//   start_drop  registered one-cycle pulse: start_in seen while ready=0
//   wake_cnt    saturating wake counter (only with ALU_PWR_STATS_EN)
//   state       current FSM state encoding
//
// Handshake: req is a level the requester raises and holds until it sees
// ready=1; ready=1 means start_in is forwarded to the ALU in the same cycle.
// A start_in while ready=0 is discarded and reported on start_drop; it never
// wakes the domain on its own.
// -----------------------------------------------------------------------------
module alu_pwr_seq #(
    parameter int PWRUP_CYC     = 4,
    parameter int ISO_SETUP_CYC = 2,
    parameter int IDLE_CYC      = 16,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic             force_on,
    input  logic             start_in,
    input  logic             busy,
    output logic             alu_pwr_en,
    output logic             iso_en,
    output logic             ready,
    output logic             start_out,
    output logic             start_drop,
`ifdef ALU_PWR_STATS_EN
    output logic [CNT_W-1:0] wake_cnt,
`endif
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        OFF    = 3'd0,
        PWR_UP = 3'd1,
        UNISO  = 3'd2,
        ON     = 3'd3,
        ISO    = 3'd4,
        PWR_DN = 3'd5
    } state_t;

    // Terminal counts: a phase of N cycles ends when the counter shows N-1.
    localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(PWRUP_CYC - 1);
    localparam logic [CNT_W-1:0] ISO_LAST   = CNT_W'(ISO_SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(IDLE_CYC - 1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             pwr_d;
    logic             iso_d;
    logic             rdy_d;
    logic             wake_req;
    logic             active;

    assign wake_req = req | force_on;
    assign active   = req | force_on | start_in | busy;

    // One counter serves every timed phase; it is cleared on each state
    // change so each phase starts counting from zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            OFF: begin
                cnt_d = '0;
                if (wake_req) begin
                    state_d = PWR_UP;
                end
            end
            PWR_UP: begin
                // Dropping req here does not abort the power-up.
                if (cnt_q == PWRUP_LAST) begin
                    state_d = UNISO;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            UNISO: begin
                // One settling cycle for the ALU outputs before ready.
                state_d = ON;
                cnt_d   = '0;
            end
            ON: begin
                // cnt_q counts consecutive idle cycles here.
                if (active) begin
                    cnt_d = '0;
                end else if (cnt_q == IDLE_LAST) begin
                    state_d = ISO;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ISO: begin
                // Power is still on, so a new request can simply re-release
                // isolation instead of completing the shutdown.
                if (wake_req) begin
                    state_d = UNISO;
                    cnt_d   = '0;
                end else if (cnt_q == ISO_LAST) begin
                    state_d = PWR_DN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PWR_DN: begin
                state_d = OFF;
                cnt_d   = '0;
            end
            default: begin
                state_d = OFF;
                cnt_d   = '0;
            end
        endcase
    end

    // Moore outputs decoded from the next state so they leave a flop together
    // with the state register.
    always_comb begin
        pwr_d = 1'b0;
        iso_d = 1'b1;
        rdy_d = 1'b0;
        case (state_d)
            PWR_UP: pwr_d = 1'b1;
            UNISO: begin
                pwr_d = 1'b1;
                iso_d = 1'b0;
            end
            ON: begin
                pwr_d = 1'b1;
                iso_d = 1'b0;
                rdy_d = 1'b1;
            end
            ISO:     pwr_d = 1'b1;
            default: pwr_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= OFF;
            cnt_q      <= '0;
            alu_pwr_en <= 1'b0;
            iso_en     <= 1'b1;
            ready      <= 1'b0;
            start_drop <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            alu_pwr_en <= pwr_d;
            iso_en     <= iso_d;
            ready      <= rdy_d;
            start_drop <= start_in & ~ready;
        end
    end

    assign start_out = start_in & ready;
    assign state     = state_q;

`ifdef ALU_PWR_STATS_EN
    // Only genuine OFF->PWR_UP wakes count; ISO->UNISO aborts do not.
    logic wake_evt;
    assign wake_evt = (state_q == OFF) && wake_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            wake_cnt <= '0;
        end else if (wake_evt && (wake_cnt != '1)) begin
            wake_cnt <= wake_cnt + 1'b1;
        end
    end
`endif

endmodule
